mem_access_ctrl: RTL and testbench

//  Initiator side of the data MEMORY port (WRITE_EN/READ_EN/ADDRESS/DATA_IN/DATA_OUT_REG).

---
 rtl/mem_access_ctrl_if.sv | 37 +++
 rtl/mem_access_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request/response and memory port bundle for mem_access_ctrl
//
// Purpose: groups the MEM-stage request handshake, the completion response and
//          the word-wide MEMORY port into one interface.
// Modports:
//   slave  - the controller: takes req_* and mem_data_out, drives req_ready,
//            resp_* and the mem_* strobes/address/data.
//   master - the requester plus memory side (opposite directions).
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output mem_write_en, mem_read_en, mem_address, mem_data_in
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  mem_write_en, mem_read_en, mem_address, mem_data_in
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MIPS32 MEM-stage byte/half/word access controller
//
// Purpose: turns byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into word
//          accesses on the data MEMORY port. Sub-word stores use read-modify-
//          write, loads are lane-extracted and sign/zero-extended, misaligned,
//          illegal-size and out-of-range requests complete with an error.
// Ports:
//   i_clk   - clock, rising edge
//   i_rst_n - asynchronous active-low reset
//   bus     - mem_access_ctrl_if.slave (request, response, MEMORY port)
module mem_access_ctrl #(
  parameter int MEM_SIZE = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  mem_access_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RD_ISSUE  = 3'd1;
  localparam logic [2:0] S_RD_CAPT   = 3'd2;
  localparam logic [2:0] S_WR        = 3'd3;
  localparam logic [2:0] S_RMW_RD    = 3'd4;
  localparam logic [2:0] S_RMW_MERGE = 3'd5;
  localparam logic [2:0] S_RMW_WR    = 3'd6;

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_SIZE * 4);

  logic [2:0]  r_state;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic        r_mem_we;
  logic        r_mem_re;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_din;

  logic        w_ready;
  logic        w_accept;
  logic        w_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  // Ready is forced low while reset is held, not just by the registered state.
  assign w_ready  = (r_state == S_IDLE) && i_rst_n;
  assign w_accept = bus.req_valid && w_ready;

  always_comb begin
    w_err = 1'b0;
    case (bus.req_size)
      2'b00:   w_err = 1'b0;
      2'b01:   w_err = bus.req_addr[0];
      2'b10:   w_err = |bus.req_addr[1:0];
      default: w_err = 1'b1;
    endcase
    if (bus.req_addr >= ADDR_LIMIT) w_err = 1'b1;
  end

  // Lane extraction of the word returned by MEMORY (little-endian lanes).
  always_comb begin
    w_byte = bus.mem_data_out[{r_lane, 3'b000} +: 8];
    w_half = r_lane[1] ? bus.mem_data_out[31:16] : bus.mem_data_out[15:0];
    case (r_size)
      2'b00:   w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load_data = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load_data = bus.mem_data_out;
    endcase
  end

  // Store lane dropped into the old word; other lanes pass through untouched.
  always_comb begin
    w_merged = bus.mem_data_out;
    if (r_size == 2'b00) w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    else                 w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_lane       <= 2'b00;
      r_wdata      <= 16'h0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_mem_we     <= 1'b0;
      r_mem_re     <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_mem_din    <= 32'h0;
    end else begin
      // Strobes and the response are single-cycle pulses by default.
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_mem_we     <= 1'b0;
      r_mem_re     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else begin
              r_size     <= bus.req_size;
              r_signed   <= bus.req_signed;
              r_lane     <= bus.req_addr[1:0];
              r_wdata    <= bus.req_wdata[15:0];
              r_mem_addr <= {2'b00, bus.req_addr[31:2]};
              if (!bus.req_write) begin
                r_mem_re <= 1'b1;
                r_state  <= S_RD_ISSUE;
              end else if (bus.req_size == 2'b10) begin
                r_mem_we  <= 1'b1;
                r_mem_din <= bus.req_wdata;
                r_state   <= S_WR;
              end else begin
                r_mem_re <= 1'b1;
                r_state  <= S_RMW_RD;
              end
            end
          end
        end
        S_RD_ISSUE:  r_state <= S_RD_CAPT;
        S_RD_CAPT: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= w_load_data;
          r_state      <= S_IDLE;
        end
        S_WR: begin
          r_resp_valid <= 1'b1;
          r_state      <= S_IDLE;
        end
        S_RMW_RD:    r_state <= S_RMW_MERGE;
        S_RMW_MERGE: begin
          r_mem_din <= w_merged;
          r_mem_we  <= 1'b1;
          r_state   <= S_RMW_WR;
        end
        S_RMW_WR: begin
          r_resp_valid <= 1'b1;
          r_state      <= S_IDLE;
        end
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready    = w_ready;
  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_err     = r_resp_err;
  assign bus.resp_rdata   = r_resp_rdata;
  assign bus.mem_write_en = r_mem_we;
  assign bus.mem_read_en  = r_mem_re;
  assign bus.mem_address  = r_mem_addr;
  assign bus.mem_data_in  = r_mem_din;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;
  localparam int MEM_SIZE = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.MEM_SIZE(MEM_SIZE)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Word-wide MEMORY: READ_EN sampled at an edge, data registered for the next cycle.
  logic [31:0] mem [MEM_SIZE];
  logic [31:0] mem_dout;
  assign bus.mem_data_out = mem_dout;
  always @(posedge clk) begin
    if (bus.mem_write_en) mem[bus.mem_address[9:0]] <= bus.mem_data_in;
    if (bus.mem_read_en)  mem_dout <= mem[bus.mem_address[9:0]];
  end

  // Activity monitor, sampled away from the active edge.
  int cyc = 0, n_re = 0, n_we = 0, n_both = 0, n_resp = 0;
  logic [31:0] last_re_addr, last_we_addr;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bus.mem_read_en)  begin n_re++; last_re_addr = bus.mem_address; end
    if (bus.mem_write_en) begin n_we++; last_we_addr = bus.mem_address; end
    if (bus.mem_read_en && bus.mem_write_en) n_both++;
    if (bus.resp_valid) n_resp++;
  end

  // Reference model: byte-addressed little-endian memory.
  logic [7:0] ref_b [MEM_SIZE*4];

  function automatic logic ref_err(logic [31:0] a, logic [1:0] sz);
    if (sz == 2'd3) return 1'b1;
    if (longint'(a) >= longint'(MEM_SIZE) * 4) return 1'b1;
    return (longint'(a) % (longint'(1) << sz)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] a, logic [1:0] sz, logic sgn);
    longint v = 0;
    int n = 1 << sz;
    for (int k = n - 1; k >= 0; k--) v = v * 256 + longint'(ref_b[int'(a) + k]);
    if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(logic [31:0] a, logic [1:0] sz, logic [31:0] wd);
    for (int k = 0; k < (1 << sz); k++) ref_b[int'(a) + k] = 8'(wd >> (8 * k));
  endtask

  // One request: waits for ready, measures edges from accept to response.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic got, output logic err, output logic [31:0] rd,
                        output int lat, output int dre, output int dwe);
    int g, re0, we0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_size = sz;
    bus.req_signed = sgn; bus.req_addr = a; bus.req_wdata = wd;
    g = 0;
    while (!bus.req_ready && g < 20) begin @(negedge clk); g++; end
    re0 = n_re; we0 = n_we;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin @(negedge clk); lat++; end
    got = bus.resp_valid; err = bus.resp_err; rd = bus.resp_rdata;
    dre = n_re - re0; dwe = n_we - we0;
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
  } row_t;

  task automatic test_reset;
    logic got, err; logic [31:0] rd; int lat, dre, dwe, we0, rs0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_read_en, bus.mem_write_en,
         bus.resp_rdata, bus.mem_address, bus.mem_data_in} !== '0)
      begin errors++; $display("FAIL reset_outputs: got ready=%b rv=%b re=%b we=%b addr=%h din=%h, required all 0",
        bus.req_ready, bus.resp_valid, bus.mem_read_en, bus.mem_write_en, bus.mem_address, bus.mem_data_in); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b required 1", bus.req_ready); end

    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, got, err, rd, lat, dre, dwe);
    ref_store(32'h20, 2'd2, 32'h11223344);

    // SB 0x21 aborted by reset while in the merge cycle.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = 32'h21; bus.req_wdata = 32'hEE;
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rmw_ready: got %b required 1", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    we0 = n_we; rs0 = n_resp;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.mem_read_en, bus.mem_write_en, bus.mem_data_in} !== '0)
      begin errors++; $display("FAIL rmw_abort_outputs: got ready=%b rv=%b re=%b we=%b din=%h, required all 0",
        bus.req_ready, bus.resp_valid, bus.mem_read_en, bus.mem_write_en, bus.mem_data_in); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (n_we !== we0 || n_resp !== rs0 || mem[8] !== 32'h11223344 || bus.req_ready !== 1'b1)
      begin errors++; $display("FAIL rmw_abort_effects: got writes=%0d resps=%0d word8=%h ready=%b, required 0 0 11223344 1",
        n_we - we0, n_resp - rs0, mem[8], bus.req_ready); end

    // LW aborted while READ_EN is high: the strobe must drop without an edge.
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h20;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rs0 = n_resp;
    checks++;
    if (bus.mem_read_en !== 1'b1) begin errors++; $display("FAIL load_issue: got read_en=%b required 1", bus.mem_read_en); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_read_en !== 1'b0) begin errors++; $display("FAIL async_drop: got read_en=%b required 0", bus.mem_read_en); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (n_resp !== rs0) begin errors++; $display("FAIL load_abort_resp: got %0d responses required 0", n_resp - rs0); end
  endtask

  task automatic test_directed;
    row_t rows[10];
    logic got, err; logic [31:0] rd; int lat, dre, dwe, e_lat, e_re, e_we;
    rows[0] = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0};
    rows[1] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
    rows[2] = '{1'b1, 2'd0, 1'b0, 32'h13, 32'hA5,       32'h0};
    rows[3] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hA5ADBEEF};
    rows[4] = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'hFFFFFFA5};
    rows[5] = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'h000000A5};
    rows[6] = '{1'b1, 2'd1, 1'b0, 32'h12, 32'h8001,     32'h0};
    rows[7] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h8001BEEF};
    rows[8] = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'hFFFF8001};
    rows[9] = '{1'b0, 2'd1, 1'b0, 32'h10, 32'h0,        32'h0000BEEF};
    for (int i = 0; i < 10; i++) begin
      e_lat = !rows[i].wr ? 3 : (rows[i].sz == 2'd2 ? 2 : 4);
      e_re  = (rows[i].wr && rows[i].sz == 2'd2) ? 0 : 1;
      e_we  = rows[i].wr ? 1 : 0;
      do_req(rows[i].wr, rows[i].sz, rows[i].sgn, rows[i].a, rows[i].wd, got, err, rd, lat, dre, dwe);
      if (rows[i].wr) ref_store(rows[i].a, rows[i].sz, rows[i].wd);
      checks++;
      if (!got || lat !== e_lat) begin errors++; $display("FAIL dir%0d_latency: got %0d edges (resp=%b) required %0d", i, lat, got, e_lat); end
      checks++;
      if (err !== 1'b0 || rd !== rows[i].rd) begin errors++; $display("FAIL dir%0d_data: got err=%b rdata=%h required err=0 rdata=%h", i, err, rd, rows[i].rd); end
      checks++;
      if (dre !== e_re || dwe !== e_we) begin errors++; $display("FAIL dir%0d_enables: got re=%0d we=%0d required re=%0d we=%0d", i, dre, dwe, e_re, e_we); end
      checks++;
      if ((e_re == 1 && last_re_addr !== 32'd4) || (e_we == 1 && last_we_addr !== 32'd4))
        begin errors++; $display("FAIL dir%0d_address: got rd_addr=%h wr_addr=%h required 4", i, last_re_addr, last_we_addr); end
    end
  endtask

  task automatic test_errors;
    row_t rows[6];
    logic got, err; logic [31:0] rd; int lat, dre, dwe;
    rows[0] = '{1'b0, 2'd2, 1'b0, 32'h11,       32'h0, 32'h0};
    rows[1] = '{1'b1, 2'd1, 1'b0, 32'h13,       32'h1234, 32'h0};
    rows[2] = '{1'b0, 2'd3, 1'b0, 32'h10,       32'h0, 32'h0};
    rows[3] = '{1'b1, 2'd3, 1'b0, 32'h10,       32'hFFFFFFFF, 32'h0};
    rows[4] = '{1'b0, 2'd2, 1'b0, 32'h1000,     32'h0, 32'h0};
    rows[5] = '{1'b1, 2'd0, 1'b0, 32'hFFFFFFFF, 32'h77, 32'h0};
    for (int i = 0; i < 6; i++) begin
      do_req(rows[i].wr, rows[i].sz, rows[i].sgn, rows[i].a, rows[i].wd, got, err, rd, lat, dre, dwe);
      checks++;
      if (!got || lat !== 1 || err !== 1'b1 || rd !== 32'h0)
        begin errors++; $display("FAIL err%0d_resp: got resp=%b edges=%0d err=%b rdata=%h required 1 1 1 0", i, got, lat, err, rd); end
      checks++;
      if (dre !== 0 || dwe !== 0) begin errors++; $display("FAIL err%0d_enables: got re=%0d we=%0d required 0 0", i, dre, dwe); end
    end
    checks++;
    if (mem[4] !== 32'h8001BEEF) begin errors++; $display("FAIL err_word4: got %h required 8001BEEF", mem[4]); end
  endtask

  task automatic test_random;
    logic got, err, wr, sgn, e_err; logic [1:0] sz; logic [31:0] a, wd, rd, e_rd;
    int lat, dre, dwe, e_lat, e_re, e_we, r;
    for (int w = 0; w < 32; w++) begin
      wd = $urandom;
      do_req(1'b1, 2'd2, 1'b0, 32'(4 * w), wd, got, err, rd, lat, dre, dwe);
      ref_store(32'(4 * w), 2'd2, wd);
    end
    for (int n = 0; n < 300; n++) begin
      wr  = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      wd  = $urandom;
      r   = int'($urandom_range(0, 9));
      if (r == 0)      a = 32'(MEM_SIZE * 4) + 32'($urandom_range(0, 64));
      else if (r == 1) a = $urandom;
      else             a = 32'($urandom_range(0, 127));
      e_err = ref_err(a, sz);
      e_rd  = (e_err || wr) ? 32'h0 : ref_load(a, sz, sgn);
      e_lat = e_err ? 1 : (!wr ? 3 : (sz == 2'd2 ? 2 : 4));
      e_re  = (!e_err && !(wr && sz == 2'd2)) ? 1 : 0;
      e_we  = (!e_err && wr) ? 1 : 0;
      do_req(wr, sz, sgn, a, wd, got, err, rd, lat, dre, dwe);
      if (wr && !e_err) ref_store(a, sz, wd);
      checks++;
      if (!got || lat !== e_lat) begin errors++; $display("FAIL rnd%0d_latency: got %0d edges (resp=%b) required %0d", n, lat, got, e_lat); end
      checks++;
      if (err !== e_err) begin errors++; $display("FAIL rnd%0d_err: got %b required %b (addr=%h size=%0d)", n, err, e_err, a, sz); end
      checks++;
      if (rd !== e_rd) begin errors++; $display("FAIL rnd%0d_rdata: got %h required %h (addr=%h size=%0d signed=%b)", n, rd, e_rd, a, sz, sgn); end
      checks++;
      if (dre !== e_re || dwe !== e_we) begin errors++; $display("FAIL rnd%0d_enables: got re=%0d we=%0d required re=%0d we=%0d", n, dre, dwe, e_re, e_we); end
    end
    for (int w = 0; w < 32; w++) begin
      checks++;
      if (mem[w] !== ref_load(32'(4 * w), 2'd2, 1'b0))
        begin errors++; $display("FAIL rnd_word%0d: got %h required %h", w, mem[w], ref_load(32'(4 * w), 2'd2, 1'b0)); end
    end
  endtask

  task automatic test_back_to_back;
    for (int pass = 0; pass < 2; pass++) begin
      int i, nr, g, prev, step;
      logic took;
      i = 0; nr = 0; g = 0; prev = -1; step = (pass == 0) ? 2 : 3;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_write = (pass == 0); bus.req_size = 2'd2;
      bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
      while ((i < MEM_SIZE || nr < MEM_SIZE) && g < 10 * MEM_SIZE) begin
        took = 1'b0;
        if (bus.resp_valid) begin
          checks++;
          if (bus.resp_err !== 1'b0 || bus.resp_rdata !== (pass == 0 ? 32'h0 : 32'(nr)))
            begin errors++; $display("FAIL b2b%0d_resp%0d: got err=%b rdata=%h required err=0 rdata=%h",
              pass, nr, bus.resp_err, bus.resp_rdata, (pass == 0 ? 32'h0 : 32'(nr))); end
          nr++;
        end
        if (i < MEM_SIZE && bus.req_valid && bus.req_ready) begin
          if (prev >= 0) begin
            checks++;
            if (cyc - prev !== step) begin errors++; $display("FAIL b2b%0d_spacing%0d: got %0d cycles required %0d", pass, i, cyc - prev, step); end
          end
          prev = cyc; took = 1'b1;
          if (pass == 0) ref_store(32'(4 * i), 2'd2, 32'(i));
          i++;
        end
        @(negedge clk);
        g++;
        if (took) begin
          if (i < MEM_SIZE) begin bus.req_addr = 32'(4 * i); bus.req_wdata = 32'(i); end
          else bus.req_valid = 1'b0;
        end
      end
      bus.req_valid = 1'b0;
      checks++;
      if (nr !== MEM_SIZE) begin errors++; $display("FAIL b2b%0d_count: got %0d responses required %0d", pass, nr, MEM_SIZE); end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    #2;
    test_reset;
    test_directed;
    test_errors;
    test_random;
    test_back_to_back;
    checks++;
    if (n_both !== 0) begin errors++; $display("FAIL enable_exclusive: got %0d cycles with both enables required 0", n_both); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout at %0d cycles required completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
